// File: rtl/regfile_pkg.sv
// Shared widths, enable levels and sequencer state encoding for the OpenMIPS register file.
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic RST_ENABLE   = 1'b1;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;

  typedef enum logic {
    CLEAR = ST_CLEAR,
    READY = ST_READY
  } rf_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read mux of the register file: $0 and busy force zero, a same-cycle write bypasses memory.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              busy,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (busy || raddr == '0 || re != READ_ENABLE) begin
      rdata = '0;
    end else if (we == WRITE_ENABLE && waddr == raddr) begin
      rdata = wdata;
    end else begin
      rdata = mem_data;
    end
  end

endmodule

// File: rtl/regfile.sv
// 32-entry register file with write-through bypass, hardwired $0, a post-reset
// clearing sequencer and a registered debug read port.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | zeroing one entry per edge; reads, writes and debug are masked
// READY | normal operation: WB writes, ID reads, debug snapshots
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] mem [NUM_REGS];
  rf_state_t         state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] dbg_next;
  logic              busy;

  assign busy   = (rst == RST_ENABLE) || (state == CLEAR);
  assign busy_o = busy;

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .busy     (busy),
    .re       (re1),
    .raddr    (raddr1),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .mem_data (mem[raddr1]),
    .rdata    (rdata1)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .busy     (busy),
    .re       (re2),
    .raddr    (raddr2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .mem_data (mem[raddr2]),
    .rdata    (rdata2)
  );

  // Debug port always reads; busy masking keeps it at zero through CLEAR.
  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_dbg (
    .busy     (busy),
    .re       (READ_ENABLE),
    .raddr    (dbg_addr),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .mem_data (mem[dbg_addr]),
    .rdata    (dbg_next)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      dbg_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          mem[clr_idx] <= '0;
          clr_idx      <= clr_idx + 1'b1;
          dbg_data     <= '0;
          if (clr_idx == LAST_IDX) begin
            state <= READY;
          end
        end
        READY: begin
          if (we == WRITE_ENABLE && waddr != '0) begin
            mem[waddr] <= wdata;
          end
          dbg_data <= dbg_next;
        end
        default: begin
          state    <= CLEAR;
          clr_idx  <= '0;
          dbg_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: expectations queued at drive time, popped when outputs are sampled.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        busy_o;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t comb_q[$];
  sb_t dbg_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  regfile dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_comb(input int sel, input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    comb_q.push_back(e);
  endtask

  task automatic expect_dbg(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.sel = 3; e.exp = exp;
    dbg_q.push_back(e);
  endtask

  // Combinational outputs settle shortly after the inputs are driven.
  task automatic drain_comb();
    sb_t         e;
    logic [31:0] obs;
    #1;
    while (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      case (e.sel)
        0:       obs = rdata1;
        1:       obs = rdata2;
        default: obs = {31'b0, busy_o};
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  // One clock: registered debug expectations are compared just after the edge.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    while (dbg_q.size() > 0) begin
      e = dbg_q.pop_front();
      chk(e.tag, dbg_data, e.exp);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0; dbg_addr = '0;

    @(negedge clk);
    expect_comb(2, "busy_in_rst", 32'd1);
    expect_comb(0, "rd1_in_rst", 32'd0);
    drain_comb();
    expect_dbg("dbg_after_rst", 32'd0);
    tick();

    // Release reset: busy for exactly 32 edges, reg 7 reads zero throughout.
    rst = 1'b0; re1 = 1'b1; raddr1 = 5'd7;
    for (int i = 0; i < 32; i++) begin
      expect_comb(2, "busy_clear", 32'd1);
      expect_comb(0, "rd7_clear", 32'd0);
      drain_comb();
      tick();
    end
    expect_comb(2, "busy_ready", 32'd0);
    expect_comb(0, "rd7_ready", 32'd0);
    drain_comb();

    // Plain write then read.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 1'b0; raddr1 = 5'd5;
    expect_comb(0, "rd5_re_off_wr", 32'd0);
    drain_comb();
    tick();
    we = 1'b0; re1 = 1'b1;
    expect_comb(0, "rd5_mem", 32'hDEADBEEF);
    drain_comb();
    re1 = 1'b0;
    expect_comb(0, "rd5_re_off", 32'd0);
    drain_comb();

    // Same-cycle bypass on both ports.
    we = 1'b1; waddr = 5'd9; wdata = 32'h12345678;
    re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd9;
    expect_comb(0, "byp_rd1", 32'h12345678);
    expect_comb(1, "byp_rd2", 32'h12345678);
    drain_comb();
    tick();
    we = 1'b0;
    expect_comb(0, "mem9_rd1", 32'h12345678);
    expect_comb(1, "mem9_rd2", 32'h12345678);
    drain_comb();
    raddr2 = 5'd5;
    expect_comb(1, "rd2_reg5", 32'hDEADBEEF);
    drain_comb();

    // Writes to $0 are dropped on every port.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; dbg_addr = 5'd0;
    raddr1 = 5'd0; re1 = 1'b1;
    expect_comb(0, "r0_byp", 32'd0);
    drain_comb();
    expect_dbg("dbg_r0_wr", 32'd0);
    tick();
    we = 1'b0; raddr2 = 5'd0; re2 = 1'b1;
    expect_comb(0, "r0_rd1", 32'd0);
    expect_comb(1, "r0_rd2", 32'd0);
    drain_comb();
    expect_dbg("dbg_r0", 32'd0);
    tick();

    // Debug latency: value appears one edge after dbg_addr, not before.
    we = 1'b1; waddr = 5'd31; wdata = 32'hA5A5A5A5;
    tick();
    we = 1'b0; dbg_addr = 5'd31;
    #1;
    chk("dbg_not_before", dbg_data, 32'd0);
    expect_dbg("dbg_r31", 32'hA5A5A5A5);
    tick();
    we = 1'b1; waddr = 5'd12; wdata = 32'hCAFEF00D; dbg_addr = 5'd12;
    expect_dbg("dbg_byp", 32'hCAFEF00D);
    tick();
    we = 1'b0; dbg_addr = 5'd9;
    expect_dbg("dbg_r9", 32'h12345678);
    tick();

    // Reset mid-clear at clr_idx=10 restarts the full 32-edge clear.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    expect_comb(2, "busy_midrst", 32'd1);
    drain_comb();
    tick();
    rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'h11111111;
    re1 = 1'b1; raddr1 = 5'd5; dbg_addr = 5'd5;
    for (int i = 0; i < 32; i++) begin
      expect_comb(2, "busy_reclear", 32'd1);
      expect_comb(0, "rd5_reclear", 32'd0);
      drain_comb();
      expect_dbg("dbg_reclear", 32'd0);
      tick();
    end
    we = 1'b0;
    expect_comb(2, "busy_ready2", 32'd0);
    expect_comb(0, "rd5_after_clr", 32'd0);
    drain_comb();
    raddr1 = 5'd31; raddr2 = 5'd9; re2 = 1'b1;
    expect_comb(0, "rd31_after_clr", 32'd0);
    expect_comb(1, "rd9_after_clr", 32'd0);
    drain_comb();
    expect_dbg("dbg5_after_clr", 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry general-purpose register file for the 5-stage OpenMIPS pipeline.
- Responder to the ID stage's two read ports (read-enable plus address in, data out, combinational).
- Accepts a single write port from the WB stage.
- Includes write-through bypass, hardwired $0, a post-reset clearing sequencer with a busy flag, and a registered debug read port for the testbench/monitor.

Parameters:
- DATA_W, 32, register data width (RegDataBus).
- ADDR_W, 5, register address width (RegAddrBus).
- NUM_REGS, 32, number of entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- we  in  1  write enable from WB (1 = WriteEnable).
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re1  in  1  read port 1 enable (1 = ReadEnable).
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data, combinational.
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data, combinational.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data, registered.
- busy_o  out  1  high while reset or clearing is in progress.

Behaviour:
- States: CLEAR, READY. State register updates only on clk rising edge.
- rst=1 at an edge:
  - state<=CLEAR, clr_idx<=0, dbg_data<=0.
  - Memory is not touched in that cycle.
  - Applies in any state, including mid-CLEAR: the clear restarts from 0.
- CLEAR:
  - Each edge with rst=0 writes 0 to mem[clr_idx] and increments clr_idx.
  - After writing index NUM_REGS-1, state<=READY.
  - Exactly NUM_REGS edges from rst deassert to READY.
- busy_o:
  - Combinationally 1 when rst=1 or state=CLEAR, else 0.
  - Reset value 1.
- While busy_o=1:
  - we is ignored.
  - rdata1=rdata2=0.
  - dbg_data updates to 0 each edge.
- READY write:
  - At an edge with we=1 and waddr!=0: mem[waddr]<=wdata.
  - Writes to address 0 are discarded.
- READY read, port n (evaluated in priority order):
  - raddr_n==0 -> 0.
  - re_n==0 -> 0.
  - we=1 and waddr==raddr_n -> wdata (same-cycle bypass, write-before-read).
  - Otherwise mem[raddr_n].
- Both ports are independent; both may read the same address or bypass simultaneously.
- Debug port:
  - dbg_data <= mem[dbg_addr] at each edge in READY, with the same $0 and bypass rules.
  - Re-enable is always 1; latency is 1 cycle.
- Simultaneous events:
  - rst has priority over everything.
  - A write in the same edge as the CLEAR->READY transition is ignored.
- No X propagation: mem contents before the first complete CLEAR are never visible on any output.

Decomposition:
- Shared defines (existing defines file): RegDataBus, RegAddrBus, RegNum, RegNumLog2, WriteEnable/ReadEnable, RstEnable, ZeroWord, NOPRegAddr.
- Add localparams for the CLEAR/READY encoding.
- One sub-module is natural: regfile_rd_port.
  - Combinational read mux with bypass and $0 handling.
  - Instantiated three times: two async ports, and the debug port feeding a flop.

Test Plan:
- Reset, then release rst -> busy_o=1 for exactly 32 cycles then 0; re1=1, raddr1=7 reads 0x00000000 throughout and after.
- READY: write we=1, waddr=5, wdata=0xDEADBEEF; next cycle re1=1, raddr1=5 -> rdata1=0xDEADBEEF; with re1=0 -> 0.
- Bypass: same cycle we=1, waddr=9, wdata=0x12345678; re1=re2=1, raddr1=raddr2=9 -> both outputs 0x12345678 in that cycle, and mem holds it afterwards.
- $0: we=1, waddr=0, wdata=0xFFFFFFFF; then raddr1=0 with re1=1 -> 0; dbg_addr=0 -> dbg_data=0.
- Reset mid-clear: assert rst at clr_idx=10 for 1 cycle -> busy_o stays 1 for a further 32 cycles after release; we=1 during CLEAR has no effect (reads of the target are 0 after READY).
- Debug latency: write 0xA5A5A5A5 to reg 31, set dbg_addr=31 -> dbg_data=0xA5A5A5A5 one edge later, not before.
